// File: rtl/axis_write_data.sv
// axis_write_data
//   AXI write data channel. Packs WIDTH_RATIO stream words into each AXI beat,
//   with the first word in the least significant lane. Completed beats pass
//   through a one-beat staging register into a beat FIFO. From there they are
//   driven on wdata/wstrb/wlast/wvalid.
//   wlast marks every AXI_BURST_LEN-th beat and the final beat of the transfer.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_length          number of stream words in the transfer
//   cfg_valid/ready     start handshake; cfg_ready is high while idle
//   data/valid/ready    input stream
//   axi_wdata/wstrb     beat data and byte strobes (unused lanes zero)
//   axi_wlast           last beat of a burst or of the transfer
//   axi_wvalid/wready   AXI write data handshake
module axis_write_data #(
    parameter int BUF_AWIDTH     = 9,
    parameter int CONFIG_DWIDTH  = 32,
    parameter int WIDTH_RATIO    = 16,
    parameter int AXI_BURST_LEN  = 16,
    parameter int AXI_DATA_WIDTH = 512,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CONFIG_DWIDTH-1:0]    cfg_length,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [DATA_WIDTH-1:0]       data,
    input  logic                        valid,
    output logic                        ready,
    output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                        axi_wlast,
    output logic                        axi_wvalid,
    input  logic                        axi_wready
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int LANE_B = DATA_WIDTH / 8;
    localparam int LW     = (WIDTH_RATIO > 1) ? $clog2(WIDTH_RATIO) : 1;
    localparam int DEPTH  = 1 << BUF_AWIDTH;
    localparam int EW     = AXI_DATA_WIDTH + STRB_W;

    localparam logic [CONFIG_DWIDTH-1:0] ONE_C   = CONFIG_DWIDTH'(1);
    localparam logic [CONFIG_DWIDTH-1:0] RATIO_C = CONFIG_DWIDTH'(WIDTH_RATIO);
    localparam logic [CONFIG_DWIDTH-1:0] BLAST_C = CONFIG_DWIDTH'(AXI_BURST_LEN - 1);
    localparam logic [LW-1:0]            LLAST_C = LW'(WIDTH_RATIO - 1);
    localparam logic [BUF_AWIDTH:0]      DEPTH_C = (BUF_AWIDTH + 1)'(DEPTH);

    localparam logic [3:0] IDLE   = 4'b0001;
    localparam logic [3:0] ACTIVE = 4'b0010;
    localparam logic [3:0] FLUSH  = 4'b0100;
    localparam logic [3:0] DONE   = 4'b1000;

    logic [3:0]                state, state_next;
    logic [CONFIG_DWIDTH-1:0]  length, total_beats;
    logic [CONFIG_DWIDTH-1:0]  word_cnt, beat_cnt, burst_cnt;
    logic [LW-1:0]             lane_cnt;

    logic [AXI_DATA_WIDTH-1:0] pack_data, pack_next;
    logic [STRB_W-1:0]         pack_strb, strb_next;
    logic [AXI_DATA_WIDTH-1:0] stage_data;
    logic [STRB_W-1:0]         stage_strb;
    logic                      stage_valid;

    logic [EW-1:0]             mem [DEPTH];
    logic [EW-1:0]             head;
    logic [BUF_AWIDTH-1:0]     wr_ptr, rd_ptr;
    logic [BUF_AWIDTH:0]       fifo_count, occupancy;
    logic                      fifo_full, fifo_empty;

    logic accept, last_word, beat_done, push, pop, last_beat;

    // The staged beat counts toward fullness so a completed beat always has
    // a FIFO slot waiting for it.
    assign occupancy  = fifo_count + {{BUF_AWIDTH{1'b0}}, stage_valid};
    assign fifo_full  = (occupancy >= DEPTH_C);
    assign fifo_empty = (fifo_count == '0);

    assign cfg_ready = (state == IDLE);
    assign ready     = (state == ACTIVE) & ~fifo_full & (word_cnt < length);
    assign accept    = valid & ready;
    assign last_word = (word_cnt == length - ONE_C);
    assign beat_done = accept & ((lane_cnt == LLAST_C) | last_word);
    assign push      = stage_valid & (fifo_count != DEPTH_C) & (state != IDLE);
    assign pop       = axi_wvalid & axi_wready;
    assign last_beat = (beat_cnt == total_beats - ONE_C);

    assign head       = mem[rd_ptr];
    assign axi_wvalid = ~fifo_empty;
    assign axi_wdata  = fifo_empty ? '0 : head[AXI_DATA_WIDTH-1:0];
    assign axi_wstrb  = fifo_empty ? '0 : head[EW-1:AXI_DATA_WIDTH];
    assign axi_wlast  = ~fifo_empty & ((burst_cnt == BLAST_C) | last_beat);

    always_comb begin
        pack_next = pack_data;
        strb_next = pack_strb;
        for (int unsigned i = 0; i < WIDTH_RATIO; i++) begin
            if (lane_cnt == LW'(i)) begin
                pack_next[i*DATA_WIDTH +: DATA_WIDTH] = data;
                strb_next[i*LANE_B +: LANE_B]         = '1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cfg_valid) begin
                    state_next = (cfg_length == '0) ? DONE : ACTIVE;
                end
            end
            ACTIVE: begin
                if (accept && last_word) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (pop && last_beat) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            length      <= '0;
            total_beats <= '0;
            word_cnt    <= '0;
            beat_cnt    <= '0;
            burst_cnt   <= '0;
            lane_cnt    <= '0;
            pack_data   <= '0;
            pack_strb   <= '0;
            stage_data  <= '0;
            stage_strb  <= '0;
            stage_valid <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                lane_cnt    <= '0;
                pack_data   <= '0;
                pack_strb   <= '0;
                stage_valid <= 1'b0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                fifo_count  <= '0;
                if (cfg_valid) begin
                    length      <= cfg_length;
                    // ceil(len/ratio) without the overflow of len+ratio-1
                    total_beats <= cfg_length / RATIO_C +
                                   {{(CONFIG_DWIDTH-1){1'b0}}, |(cfg_length % RATIO_C)};
                    word_cnt    <= '0;
                    beat_cnt    <= '0;
                    burst_cnt   <= '0;
                end
            end else begin
                if (accept) begin
                    word_cnt <= word_cnt + ONE_C;
                end
                if (beat_done) begin
                    stage_data <= pack_next;
                    stage_strb <= strb_next;
                    pack_data  <= '0;
                    pack_strb  <= '0;
                    lane_cnt   <= '0;
                end else if (accept) begin
                    pack_data <= pack_next;
                    pack_strb <= strb_next;
                    lane_cnt  <= lane_cnt + LW'(1);
                end

                if (beat_done) begin
                    stage_valid <= 1'b1;
                end else if (push) begin
                    stage_valid <= 1'b0;
                end

                if (push) begin
                    wr_ptr <= wr_ptr + BUF_AWIDTH'(1);
                end
                if (pop) begin
                    rd_ptr    <= rd_ptr + BUF_AWIDTH'(1);
                    beat_cnt  <= beat_cnt + ONE_C;
                    burst_cnt <= (burst_cnt == BLAST_C) ? '0 : burst_cnt + ONE_C;
                end
                case ({push, pop})
                    2'b10:   fifo_count <= fifo_count + (BUF_AWIDTH + 1)'(1);
                    2'b01:   fifo_count <= fifo_count - (BUF_AWIDTH + 1)'(1);
                    default: fifo_count <= fifo_count;
                endcase
            end
        end
    end

    // Beat storage carries no reset; outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {stage_strb, stage_data};
        end
    end

endmodule

// File: tb/tb_axis_write_data.sv
// Testbench for axis_write_data: table of transfers checked against a
// word-list model of the packed beats, plus zero-length and reset sequences.
module tb_axis_write_data;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  cfg_length;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [31:0]  data;
    logic         valid;
    logic         ready;
    logic [511:0] axi_wdata;
    logic [63:0]  axi_wstrb;
    logic         axi_wlast;
    logic         axi_wvalid;
    logic         axi_wready;

    int total = 0;
    int bad   = 0;
    int unsigned words [10000];

    typedef struct {
        int          len;
        int          wmode;     // 0 wready high, 1 random, 2 held low then released
        int          gaps;      // random valid gaps
        int          wordmode;  // 0 words = index, 1 random words
        int          exp_beats;
        int          exp_lasts;
        logic [63:0] exp_strb;  // strobes of final beat
    } vec_t;

    vec_t vecs [7];

    axis_write_data #(
        .BUF_AWIDTH(9), .CONFIG_DWIDTH(32), .WIDTH_RATIO(16),
        .AXI_BURST_LEN(16), .AXI_DATA_WIDTH(512), .DATA_WIDTH(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_length(cfg_length), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .data(data), .valid(valid), .ready(ready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [579:0] act, input logic [579:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic void exp_beat(input int k, input int len,
                                     output logic [511:0] d, output logic [63:0] s, output logic l);
        int idx;
        d = '0;
        s = '0;
        for (int j = 0; j < 16; j++) begin
            idx = k * 16 + j;
            if (idx < len) begin
                d[j*32 +: 32] = words[idx];
                s[j*4 +: 4]   = 4'hF;
            end
        end
        l = ((k % 16) == 15) || (k == (len + 15) / 16 - 1);
    endfunction

    task automatic do_cfg(input int len);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        cfg_valid  = 1'b1;
        cfg_length = 32'(len);
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = cfg_ready;
        end
        if (!ok) check("cfg_accept", {579'd0, cfg_ready}, 580'd1);
    endtask

    task automatic run_xfer(input int len, input int wmode, input int gaps, input int wordmode,
                            input int stop_beats,
                            output int nb, output int nl, output logic [63:0] lstrb);
        int acc, target;
        bit done, prev_stall;
        logic [511:0] pd, ed;
        logic [63:0]  ps, es;
        logic         pl, el;
        nb = 0; nl = 0; lstrb = '0; acc = 0; done = 0; prev_stall = 0;
        pd = '0; ps = '0; pl = 0;
        target = (stop_beats > 0) ? stop_beats : (len + 15) / 16;
        for (int i = 0; i < len; i++) words[i] = wordmode ? $urandom : i;
        do_cfg(len);
        for (int it = 0; it < 40000 && !done; it++) begin
            @(posedge clk); #1;
            // cfg while busy must be ignored
            cfg_valid  = (wmode == 1) && ($urandom_range(0, 7) == 0);
            cfg_length = 32'd5;
            valid = (acc < len) && (gaps == 0 || $urandom_range(0, 3) != 0);
            data  = (acc < len) ? words[acc] : 32'd0;
            case (wmode)
                0:       axi_wready = 1'b1;
                1:       axi_wready = ($urandom_range(0, 2) != 0);
                default: axi_wready = (it >= 8400);
            endcase
            @(negedge clk);
            if (wmode == 2 && it == 8399) begin
                check("hold_accepted", acc, 8192);
                check("hold_ready", {579'd0, ready}, 580'd0);
                check("hold_wvalid", {579'd0, axi_wvalid}, 580'd1);
            end
            if (valid && ready) acc++;
            if (prev_stall)
                check("stall_hold", {axi_wvalid, axi_wlast, axi_wstrb, axi_wdata}, {1'b1, pl, ps, pd});
            if (axi_wvalid && axi_wready) begin
                exp_beat(nb, len, ed, es, el);
                check($sformatf("beat%0d_data", nb), {68'd0, axi_wdata}, {68'd0, ed});
                check($sformatf("beat%0d_strb", nb), {516'd0, axi_wstrb}, {516'd0, es});
                check($sformatf("beat%0d_last", nb), {579'd0, axi_wlast}, {579'd0, el});
                if (axi_wlast) nl++;
                lstrb = axi_wstrb;
                nb++;
                if (nb == target) done = 1;
            end
            prev_stall = axi_wvalid && !axi_wready;
            pd = axi_wdata; ps = axi_wstrb; pl = axi_wlast;
        end
        if (!done) begin
            check("xfer_timeout", nb, target);
        end else if (stop_beats == 0) begin
            check("accepted_words", acc, len);
            @(posedge clk); #1;
            valid = 1'b0; axi_wready = 1'b0; cfg_valid = 1'b0;
            @(negedge clk);
            check("done_busy", {579'd0, cfg_ready}, 580'd0);
            @(negedge clk);
            check("idle_again", {579'd0, cfg_ready}, 580'd1);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int nb, nl;
        logic [63:0] ls;
        run_xfer(v.len, v.wmode, v.gaps, v.wordmode, 0, nb, nl, ls);
        check({tag, "_beats"}, nb, v.exp_beats);
        check({tag, "_lasts"}, nl, v.exp_lasts);
        check({tag, "_last_strb"}, {516'd0, ls}, {516'd0, v.exp_strb});
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int nb, nl, lowcnt;
        bit rdy_seen, wv_seen;
        logic [63:0] ls;

        vecs[0] = '{32,   0, 0, 0, 2,   1,  64'hFFFF_FFFF_FFFF_FFFF};
        vecs[1] = '{20,   0, 0, 0, 2,   1,  64'h0000_0000_0000_FFFF};
        vecs[2] = '{512,  1, 1, 1, 32,  2,  64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3] = '{9000, 2, 0, 1, 563, 36, 64'h0000_0000_FFFF_FFFF};
        vecs[4] = '{1,    1, 0, 1, 1,   1,  64'h0000_0000_0000_000F};
        vecs[5] = '{256,  1, 1, 1, 16,  1,  64'hFFFF_FFFF_FFFF_FFFF};
        vecs[6] = '{300,  1, 1, 1, 19,  2,  64'h0000_FFFF_FFFF_FFFF};

        rst_n = 1'b0; cfg_valid = 1'b0; cfg_length = '0;
        valid = 1'b0; data = '0; axi_wready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cfg_ready", {579'd0, cfg_ready}, 580'd1);
        check("rst_ready", {579'd0, ready}, 580'd0);
        check("rst_out", {axi_wvalid, axi_wlast, axi_wstrb, axi_wdata}, 578'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // zero-length transfer: brief busy, no stream or AXI activity
        do_cfg(0);
        lowcnt = 0; rdy_seen = 0; wv_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            cfg_valid = 1'b0; valid = 1'b1; data = 32'hDEAD_BEEF; axi_wready = 1'b1;
            @(negedge clk);
            if (!cfg_ready) lowcnt++;
            rdy_seen |= ready;
            wv_seen  |= axi_wvalid;
        end
        valid = 1'b0;
        check("zero_ready", {579'd0, rdy_seen}, 580'd0);
        check("zero_wvalid", {579'd0, wv_seen}, 580'd0);
        total++;
        if (lowcnt < 1 || lowcnt > 2) begin
            bad++;
            $display("FAIL zero_busy_cycles: got %0d want 1..2", lowcnt);
        end

        // asynchronous reset in the middle of a 256-word transfer
        run_xfer(256, 0, 0, 1, 5, nb, nl, ls);
        check("pre_reset_beats", nb, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_wvalid", {579'd0, axi_wvalid}, 580'd0);
        check("arst_ready", {579'd0, ready}, 580'd0);
        check("arst_cfg_ready", {579'd0, cfg_ready}, 580'd1);
        check("arst_out", {axi_wlast, axi_wstrb, axi_wdata}, 577'd0);
        valid = 1'b0; axi_wready = 1'b0; cfg_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        run_vec('{16, 0, 0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF}, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
